ex_sequencer: RTL and testbench
===============================

# ex_sequencer

Execute-stage sequencer sitting between the instruction decoder stage and the execute datapath. It owns the decoder-to-execute valid/acknowledge handshake and stalls issue when the targeted load or store queue is full. It resolves jumps and conditional branches into a registered hart-vectoring redirect, then discards wrong-path instructions already in flight. It also generates the registered zone write strobes (regfile, load queue, store queue) and a retire strobe.

## Interface
Parameters:
- C_XLEN, 32, datapath width
- C_KILL_DEPTH, 2, wrong-path instructions discarded after a redirect (1..15)

Ports:
- clk_i  in  1  clock
- clk_en_i  in  1  clock enable; when low, all state and outputs hold
- resetb_i  in  1  reset, asynchronous, active-low
- ids_dav_i  in  1  decoder has an instruction available
- ids_ack_o  out  1  instruction accepted this cycle (combinational)
- ids_zone_i  in  2  destination zone: 0 NONE, 1 REGFILE, 2 LOADQ, 3 STOREQ
- ids_cond_i  in  1  conditional branch
- ids_jump_i  in  1  unconditional jump (JAL/JALR)
- ids_link_i  in  1  jump/branch writes the link register (zone is REGFILE)
- ids_pc_i  in  C_XLEN  instruction PC
- ids_target_i  in  C_XLEN  computed branch/jump target
- cmp_result_i  in  1  ALU compare result for the current instruction (combinational)
- mtvec_i  in  C_XLEN  trap vector base
- lsq_lq_full_i  in  1  load queue full
- lsq_sq_full_i  in  1  store queue full
- regd_wr_o  out  1  regfile write strobe (registered)
- lq_wr_o  out  1  load-queue write strobe (registered)
- sq_wr_o  out  1  store-queue write strobe (registered)
- retire_o  out  1  instruction retired (registered)
- hvec_vec_strobe_o  out  1  redirect pulse (registered)
- hvec_vec_o  out  C_XLEN  redirect target
- hvec_pc_o  out  C_XLEN  PC of the redirecting instruction
- exc_strobe_o  out  1  misaligned-target exception pulse (registered)
- exc_cause_o  out  4  exception cause; 0 = instruction address misaligned

## Operation
- FSM states: RUN, KILL. A 4-bit kill counter is used in KILL.
- stall = RUN & ((zone==LOADQ & lsq_lq_full_i) | (zone==STOREQ & lsq_sq_full_i)).
- ids_ack_o = clk_en_i & ids_dav_i & ~stall. Accept = ids_ack_o.
- RUN, on accept:
  - Drive the zone strobe for ids_zone_i (NONE: no strobe).
  - Pulse retire_o.
  - taken = ids_jump_i | (ids_cond_i & cmp_result_i).
- Taken with ids_target_i[1:0]==0 (normal redirect):
  - Pulse hvec_vec_strobe_o; hvec_vec_o = ids_target_i; hvec_pc_o = ids_pc_i.
  - The link write still occurs.
  - Enter KILL with count = C_KILL_DEPTH.
- Taken with ids_target_i[1:0]!=0 (misaligned target):
  - Pulse exc_strobe_o with cause 0; pulse hvec_vec_strobe_o; hvec_vec_o = mtvec_i; hvec_pc_o = ids_pc_i.
  - Suppress the zone strobe and retire_o.
  - Enter KILL with count = C_KILL_DEPTH.
- Conditional branch not taken: no redirect; retire only.
- KILL state:
  - Ack is asserted regardless of queue-full state.
  - Each accepted instruction is dropped: no strobes, no retire, no redirect, even if it is a taken branch.
  - The counter decrements per accepted instruction, not per cycle. Cycles with ids_dav_i low do not decrement.
  - At count 1 with an accept, return to RUN.
- Strobes are single-cycle; hvec_vec_o and hvec_pc_o hold their last values between redirects.

## Timing
- Reset values: state RUN, count 0, all strobes 0, hvec_vec_o 0, hvec_pc_o 0, exc_cause_o 0.
- Latency: registered outputs appear in the cycle after accept (1 cycle), aligned with the datapath delay stage.
- While clk_en_i is low:
  - ids_ack_o is 0.
  - Registered outputs hold their values; consumers qualify them with clk_en_i.
  - The counter and state freeze.
- Full deasserting in the same cycle as dav: accept that cycle, since stall is combinational on the current full.
- Back-to-back accepts are allowed every cycle in RUN.
- The first instruction after KILL exits may be accepted in the next cycle.
- Reset asserted mid-KILL: immediately RUN, count 0, strobes 0.

## Test plan
- Reset, then 4 back-to-back REGFILE ops (dav high, fulls low) -> ack high for 4 cycles; regd_wr_o and retire_o high for 4 cycles, starting 1 cycle after the first accept.
- LOADQ op with lsq_lq_full_i=1 for 3 cycles -> ack low for 3 cycles with no strobe. Full drops -> ack high the same cycle, lq_wr_o high the next cycle. A STOREQ op is unaffected by lq full.
- JAL pc=0x100, target=0x200, link -> hvec_vec_strobe_o 1 cycle, hvec_vec_o=0x200, hvec_pc_o=0x100, regd_wr_o=1. The next 2 accepted instructions (including a taken branch) produce no strobes; the third retires.
- BEQ with cmp_result_i=0 -> no redirect, retire_o=1. Same with cmp_result_i=1, target 0x40 -> redirect to 0x40.
- JALR target=0x202, mtvec_i=0x80 -> exc_strobe_o=1, exc_cause_o=0, hvec_vec_o=0x80, regd_wr_o=0, retire_o=0; enter KILL.
- Deassert resetb_i after 1 of 2 kill instructions -> all outputs 0; the next accepted op retires normally.

Source files
------------

// File: rtl/ex_sequencer.sv
// ex_sequencer: execute-stage sequencer between decoder and execute datapath.
// Handles the decoder valid/ack handshake and stalls on a full load/store queue.
// Resolves jumps/branches into a registered redirect and discards wrong-path
// instructions afterwards. Emits registered zone write strobes and retire.
// Ports:
//   clk_i, clk_en_i, resetb_i         clock, clock enable, async active-low reset
//   ids_*                             decoder stage instruction fields / handshake
//   cmp_result_i, mtvec_i             compare result, trap vector base
//   lsq_lq_full_i, lsq_sq_full_i      queue-full backpressure
//   regd_wr_o, lq_wr_o, sq_wr_o       zone write strobes (registered)
//   retire_o                          retire strobe (registered)
//   hvec_vec_strobe_o/_vec_o/_pc_o    redirect pulse, target, redirecting PC
//   exc_strobe_o, exc_cause_o         misaligned-target exception
module ex_sequencer #(
  parameter int unsigned C_XLEN       = 32,
  parameter int unsigned C_KILL_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              clk_en_i,
  input  logic              resetb_i,
  input  logic              ids_dav_i,
  output logic              ids_ack_o,
  input  logic [1:0]        ids_zone_i,
  input  logic              ids_cond_i,
  input  logic              ids_jump_i,
  input  logic              ids_link_i,
  input  logic [C_XLEN-1:0] ids_pc_i,
  input  logic [C_XLEN-1:0] ids_target_i,
  input  logic              cmp_result_i,
  input  logic [C_XLEN-1:0] mtvec_i,
  input  logic              lsq_lq_full_i,
  input  logic              lsq_sq_full_i,
  output logic              regd_wr_o,
  output logic              lq_wr_o,
  output logic              sq_wr_o,
  output logic              retire_o,
  output logic              hvec_vec_strobe_o,
  output logic [C_XLEN-1:0] hvec_vec_o,
  output logic [C_XLEN-1:0] hvec_pc_o,
  output logic              exc_strobe_o,
  output logic [3:0]        exc_cause_o
);

  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_KILL = 1'b1;

  localparam logic [1:0] Z_REGFILE = 2'd1;
  localparam logic [1:0] Z_LOADQ   = 2'd2;
  localparam logic [1:0] Z_STOREQ  = 2'd3;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             regd_q, regd_d;
  logic             lq_q, lq_d;
  logic             sq_q, sq_d;
  logic             ret_q, ret_d;
  logic             hvs_q, hvs_d;
  logic [C_XLEN-1:0] hvec_q, hvec_d;
  logic [C_XLEN-1:0] hpc_q, hpc_d;
  logic             exc_q, exc_d;
  logic [3:0]       cause_q, cause_d;

  logic stall_c;
  logic accept_c;
  logic taken_c;
  logic misalign_c;

  // Backpressure only applies in RUN; wrong-path instructions drain regardless.
  always_comb begin
    stall_c = (state_q == S_RUN) &&
              (((ids_zone_i == Z_LOADQ)  && lsq_lq_full_i) ||
               ((ids_zone_i == Z_STOREQ) && lsq_sq_full_i));
  end

  assign accept_c   = clk_en_i & ids_dav_i & ~stall_c;
  assign ids_ack_o  = accept_c;
  assign taken_c    = ids_jump_i | (ids_cond_i & cmp_result_i);
  assign misalign_c = |ids_target_i[1:0];

  // Next-state and registered-output logic; everything holds while clk_en_i is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regd_d  = regd_q;
    lq_d    = lq_q;
    sq_d    = sq_q;
    ret_d   = ret_q;
    hvs_d   = hvs_q;
    hvec_d  = hvec_q;
    hpc_d   = hpc_q;
    exc_d   = exc_q;
    cause_d = cause_q;

    if (clk_en_i) begin
      regd_d = 1'b0;
      lq_d   = 1'b0;
      sq_d   = 1'b0;
      ret_d  = 1'b0;
      hvs_d  = 1'b0;
      exc_d  = 1'b0;

      if (accept_c) begin
        case (state_q)
          S_RUN: begin
            if (taken_c && misalign_c) begin
              // Misaligned target traps: no writeback, no retire.
              exc_d   = 1'b1;
              cause_d = CAUSE_MISALIGNED;
              hvs_d   = 1'b1;
              hvec_d  = mtvec_i;
              hpc_d   = ids_pc_i;
              state_d = S_KILL;
              cnt_d   = CNT_W'(C_KILL_DEPTH);
            end else begin
              regd_d = (ids_zone_i == Z_REGFILE) | (taken_c & ids_link_i);
              lq_d   = (ids_zone_i == Z_LOADQ);
              sq_d   = (ids_zone_i == Z_STOREQ);
              ret_d  = 1'b1;
              if (taken_c) begin
                hvs_d   = 1'b1;
                hvec_d  = ids_target_i;
                hpc_d   = ids_pc_i;
                state_d = S_KILL;
                cnt_d   = CNT_W'(C_KILL_DEPTH);
              end
            end
          end
          default: begin
            // Count down accepted wrong-path instructions, not cycles.
            if (cnt_q <= CNT_W'(1)) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      regd_q  <= 1'b0;
      lq_q    <= 1'b0;
      sq_q    <= 1'b0;
      ret_q   <= 1'b0;
      hvs_q   <= 1'b0;
      hvec_q  <= '0;
      hpc_q   <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regd_q  <= regd_d;
      lq_q    <= lq_d;
      sq_q    <= sq_d;
      ret_q   <= ret_d;
      hvs_q   <= hvs_d;
      hvec_q  <= hvec_d;
      hpc_q   <= hpc_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

  assign regd_wr_o         = regd_q;
  assign lq_wr_o           = lq_q;
  assign sq_wr_o           = sq_q;
  assign retire_o          = ret_q;
  assign hvec_vec_strobe_o = hvs_q;
  assign hvec_vec_o        = hvec_q;
  assign hvec_pc_o         = hpc_q;
  assign exc_strobe_o      = exc_q;
  assign exc_cause_o       = cause_q;

endmodule

// File: tb/tb_ex_sequencer.sv
// Testbench for ex_sequencer: directed vector table, hand-written corner
// sequences (mid-KILL reset, clock-enable hold) and random stimulus against a
// behavioural model.
module tb_ex_sequencer;

  localparam int unsigned XLEN  = 32;
  localparam int          DEPTH = 2;

  logic            clk;
  logic            clk_en;
  logic            resetb;
  logic            dav;
  logic            ack;
  logic [1:0]      zone;
  logic            cond, jump, link, cmp;
  logic [XLEN-1:0] pc, tgt, mtvec;
  logic            lqf, sqf;
  logic            regd_wr, lq_wr, sq_wr, retire, hvs, exc;
  logic [XLEN-1:0] hvec, hpc;
  logic [3:0]      cause;

  int checks = 0;
  int errors = 0;

  ex_sequencer #(.C_XLEN(XLEN), .C_KILL_DEPTH(DEPTH)) dut (
    .clk_i(clk), .clk_en_i(clk_en), .resetb_i(resetb),
    .ids_dav_i(dav), .ids_ack_o(ack), .ids_zone_i(zone),
    .ids_cond_i(cond), .ids_jump_i(jump), .ids_link_i(link),
    .ids_pc_i(pc), .ids_target_i(tgt), .cmp_result_i(cmp), .mtvec_i(mtvec),
    .lsq_lq_full_i(lqf), .lsq_sq_full_i(sqf),
    .regd_wr_o(regd_wr), .lq_wr_o(lq_wr), .sq_wr_o(sq_wr), .retire_o(retire),
    .hvec_vec_strobe_o(hvs), .hvec_vec_o(hvec), .hvec_pc_o(hpc),
    .exc_strobe_o(exc), .exc_cause_o(cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            dav;
    logic [1:0]      zone;
    logic            cond, jump, link, cmp;
    logic [XLEN-1:0] pc, tgt;
    logic            lqf, sqf;
    logic            e_ack;
    logic [5:0]      e_strb; // {regd, lq, sq, retire, hvs, exc}
    logic [XLEN-1:0] e_hv, e_hpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic d, logic [1:0] z, logic c, logic j, logic l, logic m,
                              logic [31:0] p, logic [31:0] t, logic lf, logic sf,
                              logic ea, logic [5:0] es, logic [31:0] ehv, logic [31:0] ehp);
    vec_t v;
    v.dav = d; v.zone = z; v.cond = c; v.jump = j; v.link = l; v.cmp = m;
    v.pc = p; v.tgt = t; v.lqf = lf; v.sqf = sf;
    v.e_ack = ea; v.e_strb = es; v.e_hv = ehv; v.e_hpc = ehp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [79:0] outs();
    return {6'b0, regd_wr, lq_wr, sq_wr, retire, hvs, exc, cause, hvec, hpc};
  endfunction

  function automatic logic [79:0] pack_exp(logic [5:0] s, logic [31:0] hv, logic [31:0] hp);
    return {6'b0, s, 4'd0, hv, hp};
  endfunction

  task automatic drive(input vec_t v);
    dav = v.dav; zone = v.zone; cond = v.cond; jump = v.jump; link = v.link;
    cmp = v.cmp; pc = v.pc; tgt = v.tgt; lqf = v.lqf; sqf = v.sqf;
  endtask

  task automatic idle();
    dav = 0; zone = 0; cond = 0; jump = 0; link = 0; cmp = 0;
    pc = 0; tgt = 0; lqf = 0; sqf = 0;
  endtask

  task automatic do_reset();
    idle();
    clk_en = 1'b1;
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 80'd0);
    resetb = 1'b1;
  endtask

  // Behavioural model: kill_left>0 means wrong-path instructions still to drop.
  int              m_kill;
  logic [5:0]      m_strb;
  logic [XLEN-1:0] m_hv, m_hpc;

  task automatic model_step(output logic exp_ack);
    logic full, tk;
    full = (zone == 2'd2 && lqf) || (zone == 2'd3 && sqf);
    exp_ack = clk_en && dav && (m_kill > 0 || !full);
    if (!clk_en) return;
    m_strb = 6'b0;
    if (!exp_ack) return;
    if (m_kill > 0) begin
      m_kill = m_kill - 1;
      return;
    end
    tk = jump || (cond && cmp);
    if (tk && tgt[1:0] != 2'b00) begin
      m_strb = 6'b000011;
      m_hv = mtvec; m_hpc = pc; m_kill = DEPTH;
    end else begin
      m_strb = {zone == 2'd1, zone == 2'd2, zone == 2'd3, 1'b1, tk, 1'b0};
      if (tk) begin
        m_hv = tgt; m_hpc = pc; m_kill = DEPTH;
      end
    end
  endtask

  initial begin
    logic ea;
    vec_t v;
    mtvec  = 32'h80;
    clk_en = 1'b1;
    resetb = 1'b0;
    idle();

    // dav zone c j l m pc tgt lqf sqf | ack {regd,lq,sq,ret,hvs,exc} hv hpc
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,1,0,0,0,0, 32'h0, 32'h0, 0,0, 1, 6'b100100, 32'h0, 32'h0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,2,0,0,0,0, 32'h0, 32'h0, 1,0, 0, 6'b000000, 32'h0, 32'h0));
    tbl.push_back(mk(1,2,0,0,0,0, 32'h0,   32'h0,   0,0, 1, 6'b010100, 32'h0,   32'h0));
    tbl.push_back(mk(1,3,0,0,0,0, 32'h0,   32'h0,   1,0, 1, 6'b001100, 32'h0,   32'h0));
    tbl.push_back(mk(1,1,0,1,1,0, 32'h100, 32'h200, 0,0, 1, 6'b100110, 32'h200, 32'h100));
    tbl.push_back(mk(1,1,1,0,0,1, 32'h104, 32'h300, 0,0, 1, 6'b000000, 32'h200, 32'h100));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h108, 32'h0,   0,0, 0, 6'b000000, 32'h200, 32'h100));
    tbl.push_back(mk(1,2,0,0,0,0, 32'h108, 32'h0,   1,0, 1, 6'b000000, 32'h200, 32'h100));
    tbl.push_back(mk(1,1,0,0,0,0, 32'h10c, 32'h0,   0,0, 1, 6'b100100, 32'h200, 32'h100));
    tbl.push_back(mk(1,0,1,0,0,0, 32'h110, 32'h40,  0,0, 1, 6'b000100, 32'h200, 32'h100));
    tbl.push_back(mk(1,0,1,0,0,1, 32'h114, 32'h40,  0,0, 1, 6'b000110, 32'h40,  32'h114));
    tbl.push_back(mk(1,0,0,0,0,0, 32'h118, 32'h0,   0,0, 1, 6'b000000, 32'h40,  32'h114));
    tbl.push_back(mk(1,0,0,0,0,0, 32'h11c, 32'h0,   0,0, 1, 6'b000000, 32'h40,  32'h114));
    tbl.push_back(mk(1,1,0,1,1,0, 32'h120, 32'h202, 0,0, 1, 6'b000011, 32'h80,  32'h120));

    @(posedge clk);
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #3;
      chk($sformatf("vec%0d_ack", i), {79'd0, ack}, {79'd0, tbl[i].e_ack});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out", i), outs(), pack_exp(tbl[i].e_strb, tbl[i].e_hv, tbl[i].e_hpc));
    end

    // Reset after the first of two wrong-path instructions.
    v = mk(1,1,0,0,0,0, 32'h124, 32'h0, 0,0, 0, 6'b0, 32'h0, 32'h0);
    drive(v);
    #3;
    chk("kill1_ack", {79'd0, ack}, 80'd1);
    @(posedge clk);
    #1;
    chk("kill1_out", outs(), pack_exp(6'b0, 32'h80, 32'h120));
    idle();
    resetb = 1'b0;
    #2;
    chk("midkill_reset", outs(), 80'd0);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    drive(v);
    #3;
    chk("post_reset_ack", {79'd0, ack}, 80'd1);
    @(posedge clk);
    #1;
    chk("post_reset_retire", outs(), pack_exp(6'b100100, 32'h0, 32'h0));

    // Clock enable low: no ack, registered outputs hold.
    clk_en = 1'b0;
    #3;
    chk("clken_ack", {79'd0, ack}, 80'd0);
    @(posedge clk);
    #1;
    chk("clken_hold", outs(), pack_exp(6'b100100, 32'h0, 32'h0));
    clk_en = 1'b1;
    idle();
    @(posedge clk);
    #1;
    chk("clken_resume", outs(), pack_exp(6'b000000, 32'h0, 32'h0));

    // Random stimulus against the model.
    do_reset();
    m_kill = 0; m_strb = 6'b0; m_hv = '0; m_hpc = '0;
    for (int n = 0; n < 600; n++) begin
      clk_en = ($urandom_range(0, 7) != 0);
      dav    = ($urandom_range(0, 3) != 0);
      zone   = 2'($urandom_range(0, 3));
      jump   = ($urandom_range(0, 7) == 0);
      cond   = ($urandom_range(0, 3) == 0);
      cmp    = 1'($urandom_range(0, 1));
      link   = (jump || cond) && ($urandom_range(0, 1) == 1);
      if (link) zone = 2'd1;
      pc     = {$urandom(), 2'b00} >> 0;
      pc     = {pc[31:2], 2'b00};
      tgt    = $urandom();
      if ($urandom_range(0, 3) != 0) tgt = {tgt[31:2], 2'b00};
      mtvec  = {$urandom_range(0, 32'hffff), 2'b00};
      lqf    = 1'($urandom_range(0, 1));
      sqf    = 1'($urandom_range(0, 1));
      #3;
      model_step(ea);
      chk("rnd_ack", {79'd0, ack}, {79'd0, ea});
      @(posedge clk);
      #1;
      chk("rnd_out", outs(), pack_exp(m_strb, m_hv, m_hpc));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
